// File: rtl/alu_pkg.sv
// ============================================================================
//  alu_pkg : operation codes and FSM states shared by the ALU decoder and seq_alu
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// ============================================================================
//  alu_comb : single-cycle add/sub/xor/or/and selected by the ALU control code
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    // Unused code 011 and the shift codes fall through to add.
    always_comb begin
        y_o = a_i + b_i;
        case (op_i)
            ALU_SUB: y_o = a_i - b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_AND: y_o = a_i & b_i;
            default: y_o = a_i + b_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
//  seq_alu : multi-cycle execution unit with a one-bit-per-cycle serial shifter
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUcontrol,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t               state_q;
    logic [WIDTH-1:0]     acc_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic                 dir_right_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     w_comb_y;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_serial;
    logic [WIDTH-1:0]     w_imm_d;
    logic [WIDTH-1:0]     w_acc_d;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .op_i (ALUcontrol),
        .a_i  (srcA),
        .b_i  (srcB),
        .y_o  (w_comb_y)
    );

    assign w_shamt  = srcB[SHAMT_W-1:0];
    assign w_serial = is_shift(ALUcontrol) && (w_shamt != '0);
    // A zero-amount shift completes immediately and simply returns A.
    assign w_imm_d  = is_shift(ALUcontrol) ? srcA : w_comb_y;
    assign w_acc_d  = dir_right_q ? (acc_q >> 1) : (acc_q << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (w_serial) begin
                            state_q     <= ST_SHIFT;
                            acc_q       <= srcA;
                            cnt_q       <= w_shamt;
                            dir_right_q <= (ALUcontrol == ALU_SRL);
                            busy_q      <= 1'b1;
                        end else begin
                            state_q  <= ST_DONE;
                            result_q <= w_imm_d;
                            zero_q   <= (w_imm_d == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= w_acc_d;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= w_acc_d;
                        zero_q   <= (w_acc_d == '0);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  tb_seq_alu : randomized self-checking bench for seq_alu against an arithmetic model
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  ALUcontrol;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    logic [2:0]  ns_ops [6] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b011};
    logic [2:0]  s_op [$];
    logic [31:0] s_a  [$];
    logic [31:0] s_b  [$];

    seq_alu #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ALUcontrol (ALUcontrol),
        .srcA       (srcA),
        .srcB       (srcB),
        .result     (result),
        .zero       (zero),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'b010:  return a - b;
            3'b001:  return a << sh;
            3'b101:  return a >> sh;
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'b001 || op == 3'b101) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // One operation from an idle unit; optional noise start mid-shift.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] exp;
        logic [31:0] prev;
        int          n;
        int          lat;
        bit          busy_ok;
        bit          hold_ok;
        exp     = model(op, a, b);
        n       = latency(op, b) - 1;
        prev    = result;
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; ALUcontrol = op; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; ALUcontrol = 3'($urandom); srcA = $urandom; srcB = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (noise && k == 3 && n > 3) begin
                start = 1'b1; ALUcontrol = 3'b100; srcA = $urandom; srcB = $urandom;
            end else begin
                start = 1'b0;
            end
            if (busy !== (k <= n)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (result !== prev) hold_ok = 1'b0;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(n + 1));
        check("result", result, exp);
        check("zero", {31'b0, zero}, {31'b0, exp == 32'b0});
        check("busy", {31'b0, busy_ok}, 32'd1);
        check("hold", {31'b0, hold_ok}, 32'd1);
        @(negedge clk);
        check("single_done", {31'b0, done}, 32'd0);
        check("held", result, exp);
    endtask

    // Back-to-back non-shift operations from the s_* queues, one per cycle.
    task automatic run_stream();
        logic [31:0] exp_q [$];
        int          len;
        logic [31:0] e;
        len = s_op.size();
        @(negedge clk);
        start = 1'b1; ALUcontrol = s_op[0]; srcA = s_a[0]; srcB = s_b[0];
        exp_q.push_back(model(s_op[0], s_a[0], s_b[0]));
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("b2b_done", {31'b0, done}, 32'd1);
            check("b2b_result", result, e);
            check("b2b_zero", {31'b0, zero}, {31'b0, e == 32'b0});
            if (i < len) begin
                ALUcontrol = s_op[i]; srcA = s_a[i]; srcB = s_b[i];
                exp_q.push_back(model(s_op[i], s_a[i], s_b[i]));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end", {31'b0, done}, 32'd0);
        s_op.delete(); s_a.delete(); s_b.delete();
    endtask

    task automatic reset_mid_shift();
        bit seen;
        @(negedge clk);
        start = 1'b1; ALUcontrol = 3'b001; srcA = $urandom | 32'h1; srcB = 32'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("rst_no_done", {31'b0, seen}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        ALUcontrol = 3'b000;
        srcA       = 32'b0;
        srcB       = 32'b0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_zero", {31'b0, zero}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        run_op(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        s_op.push_back(3'b010); s_a.push_back(32'd5);         s_b.push_back(32'd7);
        s_op.push_back(3'b111); s_a.push_back(32'hF0F0_F0F0); s_b.push_back(32'hFF00_FF00);
        run_stream();
        run_op(3'b001, 32'd1, 32'd31, 1'b0);
        run_op(3'b101, 32'h8000_0000, 32'h21, 1'b0);
        run_op(3'b001, 32'h0000_1234, 32'h20, 1'b0);
        run_op(3'b001, 32'h0000_00A5, 32'd10, 1'b1);
        run_op(3'b011, 32'd3, 32'd4, 1'b0);
        reset_mid_shift();

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            run_op(op, a, b, ($urandom_range(0, 1) == 1));
        end
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 8; i++) begin
                s_op.push_back(ns_ops[$urandom_range(0, 5)]);
                s_a.push_back($urandom);
                s_b.push_back($urandom);
            end
            run_stream();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
